// File: rtl/k_frame_energy_smoother.sv
// ---------------------------------------------------------------------------
// k_frame_energy_smoother
//
// Sums FRAME_LEN = 2**LOG2_FRAME per-bin energies into a frame energy. Takes
// the frame mean, then applies attack/release exponential smoothing. The
// result is published as an envelope with a threshold-exceeded flag.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   in_energy    [IN_WIDTH] unsigned bin energy from upstream
//   in_valid     upstream valid level; a 0->1 transition is one new sample
//   frame_sync   1-cycle pulse: restart frame counting, discard partial sum
//   threshold    [IN_WIDTH] unsigned compare level, sampled when publishing
//   env_out      [IN_WIDTH] smoothed frame-mean energy
//   env_valid    1-cycle pulse when env_out updates
//   over_thresh  env_out > threshold, registered together with env_out
//   overrun      sticky: a frame finished while the previous one was still
//                being post-processed (that frame is dropped)
//   peak_out     [IN_WIDTH] largest accepted bin energy of the published
//                frame (only when K_FRAME_PEAK_EN is defined)
//
// Optional feature macro: K_FRAME_PEAK_EN
// ---------------------------------------------------------------------------
module k_frame_energy_smoother #(
    parameter int IN_WIDTH      = 72,
    parameter int LOG2_FRAME    = 9,
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] in_energy,
    input  logic                in_valid,
    input  logic                frame_sync,
    input  logic [IN_WIDTH-1:0] threshold,
    output logic [IN_WIDTH-1:0] env_out,
    output logic                env_valid,
    output logic                over_thresh,
    output logic                overrun
`ifdef K_FRAME_PEAK_EN
    ,
    output logic [IN_WIDTH-1:0] peak_out
`endif
);

    // Accumulator carries LOG2_FRAME extra bits so a full frame cannot overflow.
    localparam int ACC_W = IN_WIDTH + LOG2_FRAME;
    localparam logic [LOG2_FRAME-1:0] CNT_LAST = {LOG2_FRAME{1'b1}};
    localparam logic [LOG2_FRAME-1:0] CNT_ONE  = LOG2_FRAME'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_AVG     = 2'd1;
    localparam logic [1:0] ST_SMOOTH  = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

    logic                  prev_valid_r;
    logic                  accept_s;
    logic [ACC_W-1:0]      acc_r;
    logic [ACC_W-1:0]      acc_sum_s;
    logic [LOG2_FRAME-1:0] cnt_r;
    logic [ACC_W-1:0]      snap_r;
    logic                  frame_done_r;
    logic [1:0]            state_r;
    logic [IN_WIDTH-1:0]   mean_r;
    logic [IN_WIDTH-1:0]   env_r;
    logic [IN_WIDTH-1:0]   env_next_s;

    assign accept_s  = in_valid & ~prev_valid_r;
    assign acc_sum_s = acc_r + {{LOG2_FRAME{1'b0}}, in_energy};

    // Edge detection, frame accumulation and end-of-frame snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_valid_r <= 1'b0;
            acc_r        <= '0;
            cnt_r        <= '0;
            snap_r       <= '0;
            frame_done_r <= 1'b0;
        end else begin
            prev_valid_r <= in_valid;
            frame_done_r <= 1'b0;
            // frame_sync wins over a coincident sample, which is discarded.
            if (frame_sync) begin
                acc_r <= '0;
                cnt_r <= '0;
            end else if (accept_s) begin
                if (cnt_r == CNT_LAST) begin
                    snap_r       <= acc_sum_s;
                    acc_r        <= '0;
                    cnt_r        <= '0;
                    frame_done_r <= 1'b1;
                end else begin
                    acc_r <= acc_sum_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
        end
    end

    // One attack/release smoothing step; result always lies between env and mean.
    always_comb begin
        env_next_s = env_r;
        if (mean_r >= env_r) begin
            env_next_s = env_r + ((mean_r - env_r) >> ATTACK_SHIFT);
        end else begin
            env_next_s = env_r - ((env_r - mean_r) >> RELEASE_SHIFT);
        end
    end

    // Post-process sequencer (IDLE -> AVG -> SMOOTH -> PUBLISH) and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mean_r      <= '0;
            env_r       <= '0;
            env_out     <= '0;
            env_valid   <= 1'b0;
            over_thresh <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            env_valid <= 1'b0;
            // A frame finishing while busy is dropped; the current one carries on.
            if (frame_done_r && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (frame_done_r) begin
                        state_r <= ST_AVG;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_AVG: begin
                    mean_r  <= snap_r[ACC_W-1:LOG2_FRAME];
                    state_r <= ST_SMOOTH;
                end
                ST_SMOOTH: begin
                    env_r   <= env_next_s;
                    state_r <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    env_out     <= env_r;
                    over_thresh <= (env_r > threshold);
                    env_valid   <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef K_FRAME_PEAK_EN
    logic [IN_WIDTH-1:0] peak_run_r;
    logic [IN_WIDTH-1:0] peak_snap_r;
    logic [IN_WIDTH-1:0] peak_new_s;

    assign peak_new_s = (in_energy > peak_run_r) ? in_energy : peak_run_r;

    // Running per-frame maximum, snapshotted alongside the frame sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_run_r  <= '0;
            peak_snap_r <= '0;
        end else begin
            if (frame_sync) begin
                peak_run_r <= '0;
            end else if (accept_s) begin
                if (cnt_r == CNT_LAST) begin
                    peak_snap_r <= peak_new_s;
                    peak_run_r  <= '0;
                end else begin
                    peak_run_r <= peak_new_s;
                end
            end else begin
                peak_run_r <= peak_run_r;
            end
        end
    end

    // Peak is published in the same cycle as the envelope.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_out <= '0;
        end else if (state_r == ST_PUBLISH) begin
            peak_out <= peak_snap_r;
        end else begin
            peak_out <= peak_out;
        end
    end
`endif

endmodule

// File: tb/tb_k_frame_energy_smoother.sv
// ---------------------------------------------------------------------------
// Bench for k_frame_energy_smoother. Five instances with different frame
// lengths and shifts share one stimulus stream. A frame-level model (running
// sums, a post-process countdown, plain smoothing arithmetic) predicts every
// instance's outputs each cycle. Directed scenarios pin the model with
// hand-computed literals. A randomized phase then exercises all instances.
// ---------------------------------------------------------------------------
module tb_k_frame_energy_smoother;

    localparam int NI = 5;
    localparam int W  = 72;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_energy = '0;
    logic         in_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] threshold = '0;

    logic [W-1:0] env_out_s   [NI];
    logic         env_valid_s [NI];
    logic         over_s      [NI];
    logic         ovr_s       [NI];
`ifdef K_FRAME_PEAK_EN
    logic [W-1:0] peak_s      [NI];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance table: 0:(L2,A0,R0) 1:(L2,A2,R2) 2:(L2,A0,R2) 3:(L1,A2,R6) 4:(L9,A2,R6)
    function automatic int l2_of(input int i);
        case (i)
            3: return 1;
            4: return 9;
            default: return 2;
        endcase
    endfunction
    function automatic int att_of(input int i);
        case (i)
            0, 2: return 0;
            default: return 2;
        endcase
    endfunction
    function automatic int rel_of(input int i);
        case (i)
            0: return 0;
            1, 2: return 2;
            default: return 6;
        endcase
    endfunction

`ifdef K_FRAME_PEAK_EN
`define PEAK_CONN(k) , .peak_out(peak_s[k])
`else
`define PEAK_CONN(k)
`endif

    k_frame_energy_smoother #(.IN_WIDTH(W), .LOG2_FRAME(2), .ATTACK_SHIFT(0), .RELEASE_SHIFT(0)) u_a (
        .clk(clk), .rst(rst), .in_energy(in_energy), .in_valid(in_valid), .frame_sync(frame_sync),
        .threshold(threshold), .env_out(env_out_s[0]), .env_valid(env_valid_s[0]),
        .over_thresh(over_s[0]), .overrun(ovr_s[0]) `PEAK_CONN(0));
    k_frame_energy_smoother #(.IN_WIDTH(W), .LOG2_FRAME(2), .ATTACK_SHIFT(2), .RELEASE_SHIFT(2)) u_b (
        .clk(clk), .rst(rst), .in_energy(in_energy), .in_valid(in_valid), .frame_sync(frame_sync),
        .threshold(threshold), .env_out(env_out_s[1]), .env_valid(env_valid_s[1]),
        .over_thresh(over_s[1]), .overrun(ovr_s[1]) `PEAK_CONN(1));
    k_frame_energy_smoother #(.IN_WIDTH(W), .LOG2_FRAME(2), .ATTACK_SHIFT(0), .RELEASE_SHIFT(2)) u_c (
        .clk(clk), .rst(rst), .in_energy(in_energy), .in_valid(in_valid), .frame_sync(frame_sync),
        .threshold(threshold), .env_out(env_out_s[2]), .env_valid(env_valid_s[2]),
        .over_thresh(over_s[2]), .overrun(ovr_s[2]) `PEAK_CONN(2));
    k_frame_energy_smoother #(.IN_WIDTH(W), .LOG2_FRAME(1), .ATTACK_SHIFT(2), .RELEASE_SHIFT(6)) u_d (
        .clk(clk), .rst(rst), .in_energy(in_energy), .in_valid(in_valid), .frame_sync(frame_sync),
        .threshold(threshold), .env_out(env_out_s[3]), .env_valid(env_valid_s[3]),
        .over_thresh(over_s[3]), .overrun(ovr_s[3]) `PEAK_CONN(3));
    k_frame_energy_smoother #(.IN_WIDTH(W), .LOG2_FRAME(9), .ATTACK_SHIFT(2), .RELEASE_SHIFT(6)) u_e (
        .clk(clk), .rst(rst), .in_energy(in_energy), .in_valid(in_valid), .frame_sync(frame_sync),
        .threshold(threshold), .env_out(env_out_s[4]), .env_valid(env_valid_s[4]),
        .over_thresh(over_s[4]), .overrun(ovr_s[4]) `PEAK_CONN(4));

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] smooth(input logic [W-1:0] env, input logic [W-1:0] mean,
                                            input int a, input int r);
        if (mean >= env) return env + ((mean - env) >> a);
        return env - ((env - mean) >> r);
    endfunction

    // ---------------- frame-level reference model ----------------
    logic         m_prev  [NI];
    logic [95:0]  m_sum   [NI];
    int           m_cnt   [NI];
    logic [W-1:0] m_pk    [NI];
    int           m_job   [NI];   // edges left until the pending frame is published
    logic [W-1:0] m_jmean [NI];
    logic [W-1:0] m_jpeak [NI];
    logic [W-1:0] m_env   [NI];
    logic [W-1:0] m_out   [NI];
    logic         m_val   [NI];
    logic         m_over  [NI];
    logic         m_ovr   [NI];
    logic [W-1:0] m_peak  [NI];

    always @(posedge clk or posedge rst) begin
        logic [95:0]  sum;
        int           cnt;
        int           job;
        logic [W-1:0] pk;
        logic [W-1:0] env;
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_prev[i] <= 1'b0; m_sum[i] <= '0; m_cnt[i] <= 0; m_pk[i] <= '0;
                m_job[i] <= 0; m_jmean[i] <= '0; m_jpeak[i] <= '0; m_env[i] <= '0;
                m_out[i] <= '0; m_val[i] <= 1'b0; m_over[i] <= 1'b0; m_ovr[i] <= 1'b0;
                m_peak[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                sum = m_sum[i]; cnt = m_cnt[i]; job = m_job[i]; pk = m_pk[i]; env = m_env[i];
                m_prev[i] <= in_valid;
                m_val[i]  <= 1'b0;
                if (job > 0) begin
                    job = job - 1;
                    if (job == 0) begin
                        env = smooth(env, m_jmean[i], att_of(i), rel_of(i));
                        m_out[i]  <= env;
                        m_over[i] <= (env > threshold);
                        m_val[i]  <= 1'b1;
                        m_peak[i] <= m_jpeak[i];
                    end
                end
                if (frame_sync) begin
                    sum = '0; cnt = 0; pk = '0;
                end else if (in_valid && !m_prev[i]) begin
                    sum = sum + {24'd0, in_energy};
                    cnt = cnt + 1;
                    if (in_energy > pk) pk = in_energy;
                    if (cnt == (1 << l2_of(i))) begin
                        if (job > 0) begin
                            m_ovr[i] <= 1'b1;
                        end else begin
                            job = 4;
                            m_jmean[i] <= W'(sum >> l2_of(i));
                            m_jpeak[i] <= pk;
                        end
                        sum = '0; cnt = 0; pk = '0;
                    end
                end
                m_sum[i] <= sum; m_cnt[i] <= cnt; m_job[i] <= job; m_pk[i] <= pk; m_env[i] <= env;
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("env_out[%0d]", i), {24'd0, env_out_s[i]}, {24'd0, m_out[i]});
            chk($sformatf("env_valid[%0d]", i), {95'd0, env_valid_s[i]}, {95'd0, m_val[i]});
            chk($sformatf("over_thresh[%0d]", i), {95'd0, over_s[i]}, {95'd0, m_over[i]});
            chk($sformatf("overrun[%0d]", i), {95'd0, ovr_s[i]}, {95'd0, m_ovr[i]});
`ifdef K_FRAME_PEAK_EN
            chk($sformatf("peak_out[%0d]", i), {24'd0, peak_s[i]}, {24'd0, m_peak[i]});
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; frame_sync = 1'b0; in_energy = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One sample: in_valid rises for one cycle, accept happens on the next posedge.
    task automatic send(input logic [W-1:0] e);
        @(negedge clk);
        in_valid = 1'b1; in_energy = e;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count posedges after the final accept until instance 0 publishes.
    task automatic wait_ev(output int n);
        n = 99;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (env_valid_s[0]) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        logic [95:0] r;

        // Reset state
        #1;
        chk("reset_env_out", {24'd0, env_out_s[0]}, 96'd0);
        chk("reset_env_valid", {95'd0, env_valid_s[0]}, 96'd0);
        chk("reset_over", {95'd0, over_s[0]}, 96'd0);
        chk("reset_overrun", {95'd0, ovr_s[0]}, 96'd0);
        do_reset();

        // Frame 4,8,12,16: mean 10, published 4 edges after the final accept
        threshold = 72'd9;
        send(72'd4); send(72'd8); send(72'd12); send(72'd16);
        wait_ev(n);
        chk("latency", n, 96'd4);
        chk("s1_env", {24'd0, env_out_s[0]}, 96'd10);
        chk("s1_over", {95'd0, over_s[0]}, 96'd1);
        @(posedge clk); #1;
        chk("s1_pulse_width", {95'd0, env_valid_s[0]}, 96'd0);

        // Attack on inst1 (0->25->43), release on inst2 (100->75->57)
        do_reset();
        threshold = 72'd60;
        repeat (2) begin
            repeat (4) send(72'd100);
            wait_ev(n);
        end
        chk("att_2nd_env", {24'd0, env_out_s[1]}, 96'd43);
        chk("rel_start_env", {24'd0, env_out_s[2]}, 96'd100);
        repeat (4) send(72'd0);
        wait_ev(n);
        chk("rel_1st_env", {24'd0, env_out_s[2]}, 96'd75);
        chk("rel_1st_over", {95'd0, over_s[2]}, 96'd1);
        repeat (4) send(72'd0);
        wait_ev(n);
        chk("rel_2nd_env", {24'd0, env_out_s[2]}, 96'd57);
        chk("rel_2nd_over", {95'd0, over_s[2]}, 96'd0);

        // Held-high valid gives 2 samples; frame_sync discards them
        do_reset();
        threshold = 72'd3;
        @(negedge clk); in_valid = 1'b1; in_energy = 72'd7;
        repeat (20) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); frame_sync = 1'b1;
        @(negedge clk); frame_sync = 1'b0;
        repeat (4) send(72'd5);
        wait_ev(n);
        chk("sync_env", {24'd0, env_out_s[0]}, 96'd5);
        chk("sync_over", {95'd0, over_s[0]}, 96'd1);

        // Reset while the frame sits in SMOOTH
        repeat (4) send(72'd20);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_env_out", {24'd0, env_out_s[0]}, 96'd0);
        chk("rst_over", {95'd0, over_s[0]}, 96'd0);
        chk("rst_env_valid", {95'd0, env_valid_s[0]}, 96'd0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("rst_no_publish", {95'd0, env_valid_s[0]}, 96'd0);
        end
        repeat (4) send(72'd8);
        wait_ev(n);
        chk("post_rst_env", {24'd0, env_out_s[0]}, 96'd8);

        // Peak tracking: 3,9,5,1 -> mean 4, peak 9
        repeat (4) send(72'd0);
        wait_ev(n);
        send(72'd3); send(72'd9); send(72'd5); send(72'd1);
        wait_ev(n);
        chk("peak_frame_env", {24'd0, env_out_s[0]}, 96'd4);
`ifdef K_FRAME_PEAK_EN
        chk("peak_out", {24'd0, peak_s[0]}, 96'd9);
`endif

        // Fastest possible edge rate for the 2-bin instance
        do_reset();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_energy = W'($urandom_range(0, 1000));
        end

        // Randomized traffic for all instances
        do_reset();
        for (int k = 0; k < 12000; k++) begin
            @(negedge clk);
            r = {$urandom, $urandom, $urandom};
            in_energy  = r[W-1:0];
            in_valid   = $urandom_range(0, 1) == 1;
            frame_sync = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 49) == 0) begin
                r = {$urandom, $urandom, $urandom};
                threshold = r[W-1:0];
            end
        end
        @(negedge clk);
        in_valid = 1'b0; frame_sync = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
